sccpu_fetch: RTL and testbench

SCCPU_FETCH -- requirements
Module: sccpu_fetch

---
 rtl/sccpu_pkg.sv | 17 +
 rtl/sccpu_fetch_fifo.sv | 63 ++++++
 rtl/sccpu_fetch.sv | 108 ++++++++++
 tb/tb_sccpu_fetch.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sccpu_pkg.sv
// Shared constants and types for the sccpu instruction front end.
package sccpu_pkg;

   localparam logic [31:0] SCCPU_RESET_PC    = 32'h0000_0000;
   localparam logic [31:0] SCCPU_PC_INCR     = 32'd4;
   localparam int          SCCPU_FETCH_DEPTH = 2;

   typedef enum logic {
      FETCH_RUN     = 1'b0,
      FETCH_DISCARD = 1'b1
   } fetch_state_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/sccpu_fetch_fifo.sv
// Two-entry {pc, inst} fetch buffer; entry 0 is always the head.
module sccpu_fetch_fifo
   import sccpu_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_push,
   input  logic        i_pop,
   input  logic        i_flush,
   input  logic [63:0] i_data,
   output logic [63:0] o_head,
   output logic [1:0]  o_count,
   output logic        o_full,
   output logic        o_empty
);

   logic [63:0] r_ent0;
   logic [63:0] r_ent1;
   logic [1:0]  r_count;
   logic        w_push;
   logic        w_pop;

   assign w_pop  = i_pop && (r_count != 2'd0);
   assign w_push = i_push && (!o_full || w_pop);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ent0  <= 64'd0;
         r_ent1  <= 64'd0;
         r_count <= 2'd0;
      end else if (i_flush) begin
         r_count <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) r_ent0 <= i_data;
               else                 r_ent1 <= i_data;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_ent0  <= r_ent1;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               // occupancy unchanged; the newcomer lands behind whatever remains
               if (r_count == 2'd1) begin
                  r_ent0 <= i_data;
               end else begin
                  r_ent0 <= r_ent1;
                  r_ent1 <= i_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_head  = r_ent0;
   assign o_count = r_count;
   assign o_full  = (r_count == 2'(SCCPU_FETCH_DEPTH));
   assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/sccpu_fetch.sv
// Instruction fetch: PC sequencing, one outstanding memory request, redirect handling.
//   state   | meaning
//   RUN     | responses are pushed into the buffer
//   DISCARD | a pre-redirect request is still in flight; its response is dropped
module sccpu_fetch
   import sccpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = SCCPU_RESET_PC,
   parameter int          DEPTH    = SCCPU_FETCH_DEPTH
)(
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   fetch_state_e r_state;
   fetch_state_e w_state_nxt;
   logic         r_req;
   logic [31:0]  r_addr;
   logic [31:0]  r_pc;

   logic         w_done;
   logic         w_hold;
   logic         w_push;
   logic         w_pop;
   logic         w_issue;
   logic [31:0]  w_pc_base;
   logic [1:0]   w_count;
   logic [1:0]   w_count_nxt;
   logic [63:0]  w_head;
   logic         w_full;
   logic         w_empty;

   assign w_done    = r_req && imem_ack;
   assign w_hold    = r_req && !imem_ack;
   assign w_push    = w_done && (r_state == FETCH_RUN) && !redirect && (!w_full || w_pop);
   assign w_pop     = !w_empty && inst_ready && !redirect;
   assign w_pc_base = redirect ? word_align(redirect_pc) : r_pc;

   always_comb begin
      w_count_nxt = w_count;
      if (redirect)             w_count_nxt = 2'd0;
      else if (w_push && !w_pop) w_count_nxt = w_count + 2'd1;
      else if (!w_push && w_pop) w_count_nxt = w_count - 2'd1;
   end

   // a new request is launched only if its response is guaranteed a slot
   assign w_issue = !w_hold && ((int'(w_count_nxt) + 1) <= DEPTH);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FETCH_RUN:     if (redirect && w_hold) w_state_nxt = FETCH_DISCARD;
         FETCH_DISCARD: if (w_done)             w_state_nxt = FETCH_RUN;
         default:       w_state_nxt = FETCH_RUN;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= FETCH_RUN;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_req  <= 1'b0;
         r_addr <= RESET_PC;
         r_pc   <= RESET_PC;
      end else begin
         r_req <= w_hold || w_issue;
         if (w_issue) begin
            r_addr <= w_pc_base;
            r_pc   <= w_pc_base + SCCPU_PC_INCR;
         end else begin
            r_pc   <= w_pc_base;
         end
      end
   end

   sccpu_fetch_fifo u_fifo (
      .i_clk   (clock),
      .i_rst   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (redirect),
      .i_data  ({r_addr, imem_rdata}),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign imem_req   = r_req;
   assign imem_addr  = r_addr;
   assign inst_valid = !w_empty;
   assign inst_pc    = w_head[63:32];
   assign inst       = w_head[31:0];

endmodule

// File: tb/tb_sccpu_fetch.sv
// Directed bench for sccpu_fetch: expected pcs are queued by stimulus, a monitor checks every pop.
module tb_sccpu_fetch;

   logic        clock = 1'b0;
   logic        reset, imem_ack, inst_ready, redirect;
   logic [31:0] imem_rdata, redirect_pc;
   logic        imem_req, inst_valid;
   logic [31:0] imem_addr, inst, inst_pc;

   logic        reset_2, imem_ack_2, inst_ready_2, redirect_2;
   logic [31:0] imem_rdata_2, redirect_pc_2;
   logic        imem_req_2, inst_valid_2;
   logic [31:0] imem_addr_2, inst_2, inst_pc_2;

   int          checks = 0;
   int          errors = 0;
   int          txn    = 0;
   int          t0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_q2[$];

   always #5 clock = ~clock;

   sccpu_fetch dut (
      .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
      .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
      .redirect(redirect), .redirect_pc(redirect_pc)
   );

   sccpu_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
      .clock(clock), .reset(reset_2), .imem_req(imem_req_2), .imem_addr(imem_addr_2),
      .imem_ack(imem_ack_2), .imem_rdata(imem_rdata_2), .inst_valid(inst_valid_2),
      .inst(inst_2), .inst_pc(inst_pc_2), .inst_ready(inst_ready_2),
      .redirect(redirect_2), .redirect_pc(redirect_pc_2)
   );

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: at each negedge, a pop the DUT will take at the next edge is scored.
   task automatic run_monitor();
      logic [31:0] e;
      forever begin
         @(negedge clock);
         if (!reset && imem_req && imem_ack) txn++;
         if (!reset && !redirect && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL pop_unexpected actual_pc=%h expected=none", inst_pc);
            end else begin
               e = exp_q.pop_front();
               check("pop_pc", inst_pc, e);
               check("pop_inst", inst, mem_fn(e));
            end
         end
         if (!reset_2 && !redirect_2 && inst_valid_2 && inst_ready_2) begin
            if (exp_q2.size() == 0) begin
               checks++; errors++;
               $display("FAIL pop2_unexpected actual_pc=%h expected=none", inst_pc_2);
            end else begin
               e = exp_q2.pop_front();
               check("pop2_pc", inst_pc_2, e);
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      imem_rdata   = mem_fn(imem_addr);
      imem_rdata_2 = mem_fn(imem_addr_2);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      step();
      step();
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 50 && (exp_q.size() != 0 || exp_q2.size() != 0); i++) step();
      check("drain_left", 32'(exp_q.size() + exp_q2.size()), 32'd0);
   endtask

   initial begin
      reset = 1'b1; imem_ack = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
      redirect_pc = 32'd0; imem_rdata = 32'd0;
      reset_2 = 1'b1; imem_ack_2 = 1'b1; inst_ready_2 = 1'b1; redirect_2 = 1'b0;
      redirect_pc_2 = 32'd0; imem_rdata_2 = 32'd0;
      fork run_monitor(); join_none

      step(); step();
      check("rst_req", imem_req, 1'b0);
      check("rst_valid", inst_valid, 1'b0);
      check("rst_inst", inst, 32'd0);
      check("rst_pc", inst_pc, 32'd0);
      check("rst2_req", imem_req_2, 1'b0);

      // streaming from reset, plus the wrapping instance
      exp_q  = {32'h0, 32'h4, 32'h8, 32'hC};
      exp_q2 = {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
      imem_ack = 1'b1; inst_ready = 1'b1;
      reset = 1'b0; reset_2 = 1'b0;
      step();
      check("first_req", imem_req, 1'b1);
      check("first_addr", imem_addr, 32'h0);
      check("first_valid_early", inst_valid, 1'b0);
      check("first2_addr", imem_addr_2, 32'hFFFF_FFF8);
      step();
      for (int i = 0; i < 4; i++) begin
         check("stream_valid", inst_valid, 1'b1);
         step();
      end
      wait_drain();
      inst_ready = 1'b0; inst_ready_2 = 1'b0;

      // stall: buffer fills, requests stop, acks without requests are ignored
      imem_ack = 1'b1;
      apply_reset();
      reset = 1'b0;
      t0 = txn;
      for (int i = 0; i < 5; i++) step();
      check("full_req", imem_req, 1'b0);
      check("full_txn", 32'(txn - t0), 32'd2);
      check("full_head", inst_pc, 32'h0);
      step();
      check("full_stable", inst_pc, 32'h0);
      exp_q = {32'h0, 32'h4, 32'h8};
      inst_ready = 1'b1;
      step();
      check("resume_addr", imem_addr, 32'h8);
      wait_drain();
      inst_ready = 1'b0;

      // redirect while a request is stalled
      imem_ack = 1'b1; inst_ready = 1'b1;
      apply_reset();
      exp_q = {32'h0, 32'h4, 32'h8};
      reset = 1'b0;
      for (int i = 0; i < 20 && imem_addr !== 32'h10; i++) step();
      check("reach_0x10", imem_addr, 32'h10);
      imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
      step();
      redirect = 1'b0;
      check("disc_valid", inst_valid, 1'b0);
      check("disc_req", imem_req, 1'b1);
      check("disc_addr", imem_addr, 32'h10);
      step(); step();
      check("disc_addr_hold", imem_addr, 32'h10);
      imem_ack = 1'b1;
      step();
      check("disc_new_addr", imem_addr, 32'h200);
      check("disc_dropped", inst_valid, 1'b0);
      exp_q.push_back(32'h200);
      exp_q.push_back(32'h204);
      wait_drain();
      inst_ready = 1'b0;

      // redirect coinciding with an ack
      imem_ack = 1'b1; inst_ready = 1'b1;
      apply_reset();
      exp_q = {32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18};
      reset = 1'b0;
      for (int i = 0; i < 30 && imem_addr !== 32'h20; i++) step();
      check("reach_0x20", imem_addr, 32'h20);
      check("pre_redir_head", inst_pc, 32'h1C);
      redirect = 1'b1; redirect_pc = 32'h103;
      step();
      redirect = 1'b0;
      check("same_addr", imem_addr, 32'h100);
      check("same_valid", inst_valid, 1'b0);
      exp_q.push_back(32'h100);
      exp_q.push_back(32'h104);
      wait_drain();
      inst_ready = 1'b0;

      // reset with a request outstanding and an entry buffered
      imem_ack = 1'b1; inst_ready = 1'b0;
      apply_reset();
      reset = 1'b0;
      step(); step();
      imem_ack = 1'b0;
      step(); step();
      check("mid_valid", inst_valid, 1'b1);
      check("mid_addr", imem_addr, 32'h4);
      reset = 1'b1;
      step();
      check("mid_rst_valid", inst_valid, 1'b0);
      check("mid_rst_req", imem_req, 1'b0);
      reset = 1'b0;
      step();
      check("mid_rel_addr", imem_addr, 32'h0);
      check("mid_rel_req", imem_req, 1'b1);
      exp_q = {32'h0, 32'h4};
      imem_ack = 1'b1; inst_ready = 1'b1;
      wait_drain();
      inst_ready = 1'b0;

      // second redirect while discarding takes the newer target
      imem_ack = 1'b0; inst_ready = 1'b1;
      apply_reset();
      reset = 1'b0;
      step();
      redirect = 1'b1; redirect_pc = 32'h300;
      step();
      redirect_pc = 32'h401;
      step();
      redirect = 1'b0;
      check("dd_addr_hold", imem_addr, 32'h0);
      imem_ack = 1'b1;
      step();
      check("dd_new_addr", imem_addr, 32'h400);
      exp_q = {32'h400};
      wait_drain();
      inst_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
